// File: rtl/tile_pkg.sv
// Shared lane type, state encoding and lane helper for the Piano Tiles sequencer.
package tile_pkg;

    localparam int NUM_LANES = 4;
    localparam int LANE_W    = 2;

    typedef logic [LANE_W-1:0] lane_t;

    typedef enum logic [1:0] {
        IDLE,
        FILL,
        RUN
    } seq_state_t;

    // Neighbouring lane, wrapping 3 back to 0.
    function automatic lane_t next_lane(input lane_t lane);
        return lane + lane_t'(1);
    endfunction

endpackage

// File: rtl/tile_fifo.sv
// Small lane FIFO with registered count/valid/full. A push into a full FIFO is
// accepted only when a pop happens in the same cycle.
module tile_fifo
    import tile_pkg::*;
#(
    parameter int DEPTH = 8,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = AW + 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          flush,
    input  logic          push,
    input  logic          pop,
    input  lane_t         wdata,
    output logic          push_ok,
    output logic          pop_ok,
    output lane_t         rdata,
    output logic          valid,
    output logic          full,
    output logic [CW-1:0] count
);

    lane_t         mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] count_next;

    assign pop_ok  = pop && valid;
    assign push_ok = push && (!full || pop_ok);
    assign rdata   = valid ? mem[rd_ptr] : '0;

    always_comb begin
        count_next = count;
        case ({push_ok, pop_ok})
            2'b10:   count_next = count + CW'(1);
            2'b01:   count_next = count - CW'(1);
            default: count_next = count;
        endcase
    end

    always_ff @(posedge clk) begin
        if (push_ok && !flush)
            mem[wr_ptr] <= wdata;
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            valid  <= 1'b0;
            full   <= 1'b0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            valid  <= 1'b0;
            full   <= 1'b0;
        end else begin
            if (push_ok)
                wr_ptr <= wr_ptr + AW'(1);
            if (pop_ok)
                rd_ptr <= rd_ptr + AW'(1);
            count <= count_next;
            valid <= (count_next != '0);
            full  <= (count_next == CW'(DEPTH));
        end
    end

endmodule

// File: rtl/tile_sequencer.sv
// Turns the random word into a repeat-limited stream of tile lanes buffered in a FIFO.
// Optional TILE_SEQ_STATS_EN adds a saturating spawn_count output.
module tile_sequencer
    import tile_pkg::*;
#(
    parameter int RND_BITS   = 5,
    parameter int DEPTH      = 8,
    parameter int PREFILL    = 4,
    parameter int MAX_REPEAT = 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [RND_BITS-1:0]      rnd_data,
    input  logic                     start,
    input  logic                     stop,
    input  logic                     spawn_tick,
    input  logic                     tile_ready,
    output logic                     tile_valid,
    output logic [LANE_W-1:0]        tile_lane,
    output logic [$clog2(DEPTH):0]   fill_level,
    output logic                     running,
    output logic                     overflow
`ifdef TILE_SEQ_STATS_EN
    ,
    output logic [15:0]              spawn_count
`endif
);

    localparam int CW   = $clog2(DEPTH) + 1;
    localparam int RC_W = $clog2(MAX_REPEAT + 1);

    seq_state_t      state;
    lane_t           last_lane;
    logic            last_valid;
    logic [RC_W-1:0] repeat_cnt;

    lane_t cand;
    lane_t lane;
    logic  redirect;
    logic  push_req;
    logic  push_ok;
    logic  pop_ok;
    logic  full;
    logic  fill_done;
    logic  unused_rnd;

    assign cand       = rnd_data[LANE_W-1:0];
    assign unused_rnd = ^rnd_data;
    assign redirect   = last_valid && (cand == last_lane) && (repeat_cnt == RC_W'(MAX_REPEAT));
    assign lane       = redirect ? next_lane(cand) : cand;

    assign push_req  = !stop && ((state == FILL) || ((state == RUN) && spawn_tick));
    // A simultaneous pop keeps the level flat, so only a bare push can reach PREFILL.
    assign fill_done = push_ok && !pop_ok && (fill_level == CW'(PREFILL - 1));

    tile_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .flush   (stop),
        .push    (push_req),
        .pop     (tile_ready),
        .wdata   (lane),
        .push_ok (push_ok),
        .pop_ok  (pop_ok),
        .rdata   (tile_lane),
        .valid   (tile_valid),
        .full    (full),
        .count   (fill_level)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            running    <= 1'b0;
            overflow   <= 1'b0;
            last_lane  <= '0;
            last_valid <= 1'b0;
            repeat_cnt <= '0;
        end else if (stop) begin
            state      <= IDLE;
            running    <= 1'b0;
            overflow   <= 1'b0;
            last_valid <= 1'b0;
            repeat_cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start)
                        state <= FILL;
                end
                FILL: begin
                    if (fill_done) begin
                        state   <= RUN;
                        running <= 1'b1;
                    end
                end
                RUN: begin
                    if (spawn_tick && full && !push_ok)
                        overflow <= 1'b1;
                end
                default: begin
                    state   <= IDLE;
                    running <= 1'b0;
                end
            endcase

            // Dropped tiles never reach here, so lane history only tracks accepted pushes.
            if (push_ok) begin
                if (last_valid && (lane == last_lane))
                    repeat_cnt <= repeat_cnt + RC_W'(1);
                else
                    repeat_cnt <= RC_W'(1);
                last_lane  <= lane;
                last_valid <= 1'b1;
            end
        end
    end

`ifdef TILE_SEQ_STATS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            spawn_count <= '0;
        else if (stop)
            spawn_count <= '0;
        else if (push_ok && (spawn_count != 16'hFFFF))
            spawn_count <= spawn_count + 16'd1;
    end
`endif

endmodule

// File: tb/tb_tile_sequencer.sv
// Scoreboard bench for tile_sequencer: expected lanes are queued at stimulus time
// and compared by a monitor whenever the DUT hands over a tile.
module tb_tile_sequencer;
    import tile_pkg::*;

    logic       clk        = 1'b0;
    logic       rst_n      = 1'b0;
    logic [4:0] rnd_data   = '0;
    logic       start      = 1'b0;
    logic       stop       = 1'b0;
    logic       spawn_tick = 1'b0;
    logic       tile_ready = 1'b0;
    logic       tile_valid;
    logic [1:0] tile_lane;
    logic [3:0] fill_level;
    logic       running;
    logic       overflow;
`ifdef TILE_SEQ_STATS_EN
    logic [15:0] spawn_count;
`endif

    int    total = 0;
    int    bad   = 0;
    lane_t exp_q[$];

    tile_sequencer dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .rnd_data   (rnd_data),
        .start      (start),
        .stop       (stop),
        .spawn_tick (spawn_tick),
        .tile_ready (tile_ready),
        .tile_valid (tile_valid),
        .tile_lane  (tile_lane),
        .fill_level (fill_level),
        .running    (running),
        .overflow   (overflow)
`ifdef TILE_SEQ_STATS_EN
        ,
        .spawn_count (spawn_count)
`endif
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] required);
        total++;
        if (actual !== required) begin
            bad++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, actual, required);
        end
    endtask

    // Drive one cycle of inputs, let the edge pass, then drop the pulse inputs.
    task automatic applyStimulus(input logic st, input logic sp, input logic sk, input logic [4:0] rnd);
        start      = st;
        stop       = sp;
        spawn_tick = sk;
        rnd_data   = rnd;
        @(posedge clk);
        #1;
        start      = 1'b0;
        stop       = 1'b0;
        spawn_tick = 1'b0;
    endtask

    task automatic drain(input int n);
        tile_ready = 1'b1;
        repeat (n) applyStimulus(1'b0, 1'b0, 1'b0, rnd_data);
        tile_ready = 1'b0;
    endtask

    // Each negedge with valid && ready is exactly one pop at the following edge.
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n && tile_valid && tile_ready) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("[TB] FAIL pop_unexpected: got lane %0d expected no tile", tile_lane);
                end else begin
                    checkOutput("pop_lane", 32'(tile_lane), 32'(exp_q.pop_front()));
                end
            end
        end
    end

    initial begin
        #2;
        checkOutput("reset_valid",    32'(tile_valid), 0);
        checkOutput("reset_lane",     32'(tile_lane),  0);
        checkOutput("reset_fill",     32'(fill_level), 0);
        checkOutput("reset_running",  32'(running),    0);
        checkOutput("reset_overflow", 32'(overflow),   0);
        #10 rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Prefill with rnd=2: 2,2 then redirect to 3, then 2.
        applyStimulus(1'b0, 1'b0, 1'b1, 5'h02);
        checkOutput("idle_spawn_ignored", 32'(fill_level), 0);
        applyStimulus(1'b1, 1'b0, 1'b0, 5'h02);
        exp_q.push_back(2'd2); exp_q.push_back(2'd2);
        exp_q.push_back(2'd3); exp_q.push_back(2'd2);
        repeat (3) applyStimulus(1'b0, 1'b0, 1'b0, 5'h02);
        checkOutput("prefill3_fill",    32'(fill_level), 3);
        checkOutput("prefill3_running", 32'(running),    0);
        applyStimulus(1'b0, 1'b0, 1'b0, 5'h02);
        checkOutput("prefill_fill",    32'(fill_level), 4);
        checkOutput("prefill_running", 32'(running),    1);
        checkOutput("prefill_head",    32'(tile_lane),  2);
`ifdef TILE_SEQ_STATS_EN
        checkOutput("prefill_count", 32'(spawn_count), 4);
`endif
        drain(5);
        checkOutput("drain_fill",  32'(fill_level), 0);
        checkOutput("drain_valid", 32'(tile_valid), 0);

        // Repeat wrap with rnd=3: 3,3 then redirect wraps to 0, then 3.
        applyStimulus(1'b0, 1'b1, 1'b0, 5'h03);
        checkOutput("stop_running", 32'(running), 0);
        applyStimulus(1'b1, 1'b0, 1'b0, 5'h03);
        exp_q.push_back(2'd3); exp_q.push_back(2'd3);
        exp_q.push_back(2'd0); exp_q.push_back(2'd3);
        repeat (4) applyStimulus(1'b0, 1'b0, 1'b0, 5'h03);
        checkOutput("wrap_fill", 32'(fill_level), 4);
        drain(4);

        // Overflow: restart with rnd=1 (1,1,2,1), then five spawn ticks.
        applyStimulus(1'b0, 1'b1, 1'b0, 5'h01);
        applyStimulus(1'b1, 1'b0, 1'b0, 5'h01);
        exp_q.push_back(2'd1); exp_q.push_back(2'd1);
        exp_q.push_back(2'd2); exp_q.push_back(2'd1);
        repeat (4) applyStimulus(1'b0, 1'b0, 1'b0, 5'h01);
        applyStimulus(1'b0, 1'b0, 1'b1, 5'h04); exp_q.push_back(2'd0);
        applyStimulus(1'b0, 1'b0, 1'b1, 5'h06); exp_q.push_back(2'd2);
        applyStimulus(1'b0, 1'b0, 1'b1, 5'h06); exp_q.push_back(2'd2);
        applyStimulus(1'b0, 1'b0, 1'b1, 5'h0E); exp_q.push_back(2'd3);
        checkOutput("full_fill",        32'(fill_level), 8);
        checkOutput("full_no_overflow", 32'(overflow),   0);
        applyStimulus(1'b0, 1'b0, 1'b1, 5'h1F);
        checkOutput("drop_fill",     32'(fill_level), 8);
        checkOutput("drop_overflow", 32'(overflow),   1);
        // Dropped tile left history at lane 3 x1, so another 3 is not redirected.
        tile_ready = 1'b1;
        applyStimulus(1'b0, 1'b0, 1'b1, 5'h13);
        exp_q.push_back(2'd3);
        tile_ready = 1'b0;
        checkOutput("pushpop_full_fill", 32'(fill_level), 8);
        checkOutput("overflow_sticky",   32'(overflow),   1);
        drain(8);
        checkOutput("overflow_drain_fill", 32'(fill_level), 0);

        // Handshake stall with three queued tiles 1,2,0.
        applyStimulus(1'b0, 1'b0, 1'b1, 5'h01); exp_q.push_back(2'd1);
        applyStimulus(1'b0, 1'b0, 1'b1, 5'h02); exp_q.push_back(2'd2);
        applyStimulus(1'b0, 1'b0, 1'b1, 5'h00); exp_q.push_back(2'd0);
        checkOutput("stall_fill3", 32'(fill_level), 3);
        tile_ready = 1'b1;
        applyStimulus(1'b0, 1'b0, 1'b0, 5'h00);
        tile_ready = 1'b0;
        checkOutput("stall_head_before", 32'(tile_lane), 2);
        applyStimulus(1'b0, 1'b0, 1'b0, 5'h00);
        checkOutput("stall_head_held", 32'(tile_lane),  2);
        checkOutput("stall_fill_held", 32'(fill_level), 2);
        tile_ready = 1'b1;
        applyStimulus(1'b0, 1'b0, 1'b0, 5'h00);
        tile_ready = 1'b0;
        checkOutput("stall_fill1", 32'(fill_level), 1);
        checkOutput("stall_head1", 32'(tile_lane),  0);
        drain(1);
        checkOutput("queue_drained", 32'(exp_q.size()), 0);

        // Stop on the second FILL cycle, then refill from a clean lane history.
        applyStimulus(1'b0, 1'b1, 1'b0, 5'h03);
        checkOutput("stop_clears_overflow", 32'(overflow), 0);
        applyStimulus(1'b1, 1'b0, 1'b0, 5'h03);
        applyStimulus(1'b0, 1'b0, 1'b0, 5'h03);
        applyStimulus(1'b0, 1'b1, 1'b0, 5'h03);
        checkOutput("midfill_stop_fill",     32'(fill_level), 0);
        checkOutput("midfill_stop_valid",    32'(tile_valid), 0);
        checkOutput("midfill_stop_overflow", 32'(overflow),   0);
        checkOutput("midfill_stop_running",  32'(running),    0);
        applyStimulus(1'b0, 1'b0, 1'b0, 5'h03);
        checkOutput("idle_stays_empty", 32'(fill_level), 0);
        applyStimulus(1'b1, 1'b0, 1'b0, 5'h03);
        exp_q.push_back(2'd3); exp_q.push_back(2'd3);
        exp_q.push_back(2'd0); exp_q.push_back(2'd3);
        repeat (4) applyStimulus(1'b0, 1'b0, 1'b0, 5'h03);
        checkOutput("refill_fill",    32'(fill_level), 4);
        checkOutput("refill_running", 32'(running),    1);
        tile_ready = 1'b1;
        applyStimulus(1'b0, 1'b0, 1'b0, 5'h03);
        applyStimulus(1'b0, 1'b0, 1'b0, 5'h03);
        tile_ready = 1'b0;

        // Asynchronous reset between edges while running.
        #3;
        rst_n = 1'b0;
        #1;
        exp_q.delete();
        checkOutput("async_valid",    32'(tile_valid), 0);
        checkOutput("async_lane",     32'(tile_lane),  0);
        checkOutput("async_fill",     32'(fill_level), 0);
        checkOutput("async_running",  32'(running),    0);
        checkOutput("async_overflow", 32'(overflow),   0);
`ifdef TILE_SEQ_STATS_EN
        checkOutput("async_count", 32'(spawn_count), 0);
`endif
        #10 rst_n = 1'b1;
        @(posedge clk);
        #1;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/tile_sequencer.md
Name: tile_sequencer

Overview:
Consumes the free-running 5-bit pseudo-random word and turns it into an ordered stream of tile lanes (4 lanes) for the Piano Tiles game. The sequencer enforces a maximum-repeat rule on lanes and buffers upcoming tiles in a small FIFO. The scroll/display logic pops tiles from that FIFO through a valid/ready handshake. It sits between the random generator and the tile-scroll/render logic and is paced by the game's spawn tick.

Parameters:
RND_BITS, 5, width of the random input word
DEPTH, 8, FIFO entries; power of 2, at least 2
PREFILL, 4, tiles pushed back-to-back after start; 1 to DEPTH
MAX_REPEAT, 2, maximum consecutive identical lanes; at least 1

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
rnd_data  in  RND_BITS  random word, sampled when a push occurs
start  in  1  pulse; IDLE -> FILL
stop  in  1  pulse; any state -> IDLE, flushes FIFO
spawn_tick  in  1  one-cycle pulse requesting one new tile in RUN
tile_ready  in  1  consumer accepts the head tile
tile_valid  out  1  FIFO non-empty
tile_lane  out  2  lane of the head tile
fill_level  out  $clog2(DEPTH)+1  current FIFO occupancy
running  out  1  high in RUN
overflow  out  1  sticky; a spawn_tick was dropped because the FIFO was full

Behaviour:
- Reset: every output is 0. FIFO is empty. State = IDLE. last_lane = 0, last_valid = 0, repeat_cnt = 0.
- States: IDLE, FILL, RUN.
  - IDLE -> FILL on start.
  - FILL pushes one tile every cycle. When the push brings fill_level to PREFILL, next state = RUN.
  - RUN pushes on spawn_tick when the FIFO is not full.
  - stop has priority over everything. From any state the next state is IDLE. The FIFO, last_valid, repeat_cnt and overflow are cleared in that same edge.
  - start in FILL or RUN is ignored. start and stop in the same cycle: stop wins.
- Lane generation, combinational from rnd_data:
  - Candidate lane c = rnd_data[1:0].
  - If last_valid, c == last_lane and repeat_cnt == MAX_REPEAT, then lane = (c+1) mod 4 (3 wraps to 0). Otherwise lane = c.
  - On a push: if last_valid and lane == last_lane, repeat_cnt++; otherwise repeat_cnt = 1. Then last_lane = lane and last_valid = 1.
  - The first tile after reset or stop is never redirected.
- FIFO and handshake:
  - Pop occurs when tile_valid && tile_ready. tile_lane shows the head entry and is held stable while tile_valid && !tile_ready.
  - tile_ready while empty has no effect.
  - Push and pop in the same cycle: both happen and fill_level is unchanged. This is allowed even when full, so a RUN spawn_tick is accepted when full if tile_ready is popping the head in the same cycle.
  - Pushed data becomes visible at the head one cycle after the push edge. There is no bypass.
  - Pointers wrap modulo DEPTH.
  - fill_level and tile_valid are registered and update on the same edge as the push/pop.
- Overflow: a RUN spawn_tick arriving when full with no simultaneous pop drops the tile, leaves lane state untouched and sets overflow = 1. overflow is cleared only by reset or stop.
- spawn_tick is ignored in IDLE and FILL.
- Pops are permitted in every state. A pop during FILL delays the transition until fill_level reaches PREFILL.
- running = (state == RUN), registered.

Optional Feature:
TILE_SEQ_STATS_EN
- Defined: adds output spawn_count [15:0]. It increments on every accepted push, saturates at 16'hFFFF, and clears on reset or stop.
- Undefined: the port and its counter are absent. All other behaviour is identical.

Decomposition:
- Package tile_pkg holds:
  - NUM_LANES = 4
  - LANE_W = 2
  - typedef lane_t (logic [LANE_W-1:0])
  - enum seq_state_t {IDLE, FILL, RUN}
- Sub-module tile_fifo holds the storage, pointers, count, full/empty and the push/pop-simultaneous rule. The FSM, the lane/repeat logic and the overflow flag stay in tile_sequencer.

Test Plan:
- Prefill: reset, hold rnd_data=5'h02, pulse start, tile_ready=0 -> 4 pushes on 4 consecutive cycles. Lanes at the head in order are 2, 2, 3, 2. fill_level=4, then running=1.
- Repeat wrap: MAX_REPEAT=2, rnd_data=5'h03 constant during FILL -> pushed lanes are 3, 3, 0, 3, with the redirect wrapping 3 to 0.
- Overflow: in RUN with DEPTH=8, tile_ready=0, issue 5 spawn_ticks -> fill_level reaches 8 and the 5th tick sets overflow=1. A spawn_tick with tile_ready=1 while full -> pop and push together, fill_level stays 8.
- Handshake stall: in RUN with 3 tiles queued, toggle tile_ready 1,0,1 -> tile_lane is stable during the 0 cycle, exactly 2 pops occur, fill_level=1.
- Stop mid-FILL: stop on the 2nd FILL cycle -> next edge gives state IDLE, fill_level=0, tile_valid=0, overflow=0. A following start refills with no redirect on its first tile.
- Async reset: assert rst_n low mid-RUN between clock edges -> all outputs are 0 immediately, before the next edge.
